// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, addresses the instruction memory and
// selects the next PC from jr / jump / branch / sequential requests.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jump,
  input  logic [25:0] j_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [11:0] im_addr,
  input  logic [31:0] instr,
  output logic [31:0] instr_out,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // One bit wider so a window ending at the top of the address space cannot wrap.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(IM_WORDS) * 33'd4;

  logic [31:0] br_offset;
  logic [31:0] next_pc;
  logic        next_legal;

  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{br_imm[15]}}, br_imm, 2'b00};
  assign im_addr   = pc[13:2];
  assign instr_out = instr;

  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = jr_target;
    else if (jump)
      next_pc = {pc_plus4[31:28], j_index, 2'b00};
    else if (br_taken)
      next_pc = pc_plus4 + br_offset;
  end

  assign next_legal = (next_pc[1:0] == 2'b00) &&
                      (next_pc >= RESET_PC) &&
                      ({1'b0, next_pc} < PC_LIMIT);

  // An illegal candidate latches fault, which then freezes pc and the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else if (!stall && !fault) begin
      if (next_legal) begin
        pc          <= next_pc;
        fetch_count <= fetch_count + 32'd1;
      end else begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios with literal expectations, then random
// redirect traffic checked every cycle against a behavioural PC model.
module tb_ifu;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, jump, jr;
  logic [15:0] br_imm;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [11:0] im_addr;
  logic [31:0] instr, instr_out, pc, pc_plus4, fetch_count;
  logic        fault;

  ifu dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_imm(br_imm), .jump(jump), .j_index(j_index), .jr(jr),
    .jr_target(jr_target), .im_addr(im_addr), .instr(instr),
    .instr_out(instr_out), .pc(pc), .pc_plus4(pc_plus4), .fault(fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory stand-in: each word's contents are a recognisable function of its address.
  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {a, 8'h5A, ~a};
  endfunction
  assign instr = mem_word(im_addr);

  int          n_pass = 0;
  int          n_total = 0;
  logic        chk_en = 1'b0;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: what the PC must become, from the request rules in plain arithmetic.
  task automatic model_edge();
    logic [31:0] cand;
    int          off;
    if (reset) begin
      m_pc = 32'h3000; m_fault = 1'b0; m_cnt = 0;
    end else if (!stall && !m_fault) begin
      if (jr)             cand = jr_target;
      else if (jump)      cand = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, j_index} << 2);
      else if (br_taken) begin
        off  = $signed(br_imm);
        cand = m_pc + 32'd4 + 32'(off * 4);
      end
      else                cand = m_pc + 32'd4;
      if (cand % 4 == 0 && cand >= 32'h3000 && cand <= 32'h6FFC) begin
        m_pc = cand; m_cnt = m_cnt + 1;
      end else begin
        m_fault = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("im_addr", {20'd0, im_addr}, {20'd0, m_pc[13:2]});
      check("instr_out", instr_out, mem_word(m_pc[13:2]));
      check("fault", {31'd0, fault}, {31'd0, m_fault});
      check("fetch_count", fetch_count, m_cnt);
    end
  end

  task automatic idle();
    reset = 0; stall = 0; br_taken = 0; jump = 0; jr = 0;
    br_imm = 0; j_index = 0; jr_target = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; cycle(); reset = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    do_reset();
    chk_en = 1'b1;
    check("rst_pc", pc, 32'h3000);
    check("rst_pc_plus4", pc_plus4, 32'h3004);
    check("rst_im_addr", {20'd0, im_addr}, 32'hC00);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_count", fetch_count, 32'd0);

    repeat (3) cycle();
    check("seq_pc", pc, 32'h300C);
    check("seq_count", fetch_count, 32'd3);
    check("seq_im_addr", {20'd0, im_addr}, 32'hC03);

    cycle();
    br_taken = 1; br_imm = 16'hFFFC; cycle(); idle();
    check("br_back", pc, 32'h3004);
    jr = 1; jr_target = 32'h3010; cycle(); idle();
    br_taken = 1; br_imm = 16'h0003; cycle(); idle();
    check("br_fwd", pc, 32'h3020);

    do_reset();
    jump = 1; j_index = 26'h0000C10; cycle(); idle();
    check("jump", pc, 32'h3040);
    do_reset();
    jump = 1; j_index = 26'h0000C10; jr = 1; jr_target = 32'h3100; cycle(); idle();
    check("jr_wins", pc, 32'h3100);

    do_reset();
    repeat (2) cycle();
    jr = 1; jr_target = 32'h3002; cycle(); idle();
    check("misalign_pc", pc, 32'h3008);
    check("misalign_fault", {31'd0, fault}, 32'd1);
    jump = 1; j_index = 26'h0000C20; repeat (3) cycle(); idle();
    check("frozen_pc", pc, 32'h3008);
    check("frozen_count", fetch_count, 32'd2);
    do_reset();
    check("clear_pc", pc, 32'h3000);
    check("clear_fault", {31'd0, fault}, 32'd0);

    jr = 1; jr_target = 32'h6FFC; cycle(); idle();
    check("last_word", pc, 32'h6FFC);
    cycle();
    check("past_end_pc", pc, 32'h6FFC);
    check("past_end_fault", {31'd0, fault}, 32'd1);
    do_reset();
    jr = 1; jr_target = 32'h2FFC; cycle(); idle();
    check("below_base_fault", {31'd0, fault}, 32'd1);
    check("below_base_pc", pc, 32'h3000);

    do_reset();
    stall = 1; jump = 1; j_index = 26'h0000C40; repeat (2) cycle(); idle();
    check("stall_pc", pc, 32'h3000);
    check("stall_count", fetch_count, 32'd0);
    cycle();
    check("unstall_pc", pc, 32'h3004);
    stall = 1; reset = 1; cycle(); idle();
    check("reset_over_stall", pc, 32'h3000);

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      jr        = ($urandom_range(0, 7) == 0);
      jump      = ($urandom_range(0, 7) == 0);
      br_taken  = ($urandom_range(0, 3) == 0);
      br_imm    = 16'($urandom_range(0, 40)) - 16'd20;
      jr_target = ($urandom_range(0, 7) == 0) ? $urandom
                                              : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      j_index   = ($urandom_range(0, 7) == 0) ? 26'($urandom)
                                              : 26'(32'hC00 + $urandom_range(0, 4095));
      cycle();
    end
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
